// File: rtl/wb_port_arbiter_pkg.sv
// Shared definitions for the register-file write-port arbiter.
//   DATA_W_DEF / ADDR_W_DEF : default data and address widths
//   wb_state_e              : arbitration FSM states (NORMAL, FORCE)
//   X0_ADDR                 : hard-wired zero register; writes to it are dropped
package wb_port_arbiter_pkg;

  localparam int unsigned DATA_W_DEF = 32;
  localparam int unsigned ADDR_W_DEF = 5;
  localparam int unsigned X0_ADDR    = 0;

  typedef enum logic {
    ST_NORMAL = 1'b0,
    ST_FORCE  = 1'b1
  } wb_state_e;

endpackage

// File: rtl/wb_result_fifo.sv
// Multi-cycle result queue: BUF_DEPTH entries of {valid, addr, data}.
//   push/push_addr/push_data : enqueue at tail (ignored when full)
//   pop                      : drop head (ignored when empty)
//   kill/kill_addr           : clear valid on every stored entry whose addr matches
//   head_valid/addr/data     : current head; head_valid=0 when empty or invalidated
//   full/empty               : occupancy flags from the registered count
module wb_result_fifo
  import wb_port_arbiter_pkg::*;
#(
  parameter int unsigned DATA_W    = DATA_W_DEF,
  parameter int unsigned ADDR_W    = ADDR_W_DEF,
  parameter int unsigned BUF_DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic [ADDR_W-1:0] push_addr,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  input  logic              kill,
  input  logic [ADDR_W-1:0] kill_addr,
  output logic              head_valid,
  output logic [ADDR_W-1:0] head_addr,
  output logic [DATA_W-1:0] head_data,
  output logic              full,
  output logic              empty
);

  localparam int unsigned PTR_W = $clog2(BUF_DEPTH);
  localparam int unsigned CNT_W = $clog2(BUF_DEPTH) + 1;

  logic [BUF_DEPTH-1:0] ent_valid;
  logic [ADDR_W-1:0]    ent_addr [BUF_DEPTH];
  logic [DATA_W-1:0]    ent_data [BUF_DEPTH];
  logic [PTR_W-1:0]     wr_ptr;
  logic [PTR_W-1:0]     rd_ptr;
  logic [CNT_W-1:0]     count;
  logic                 do_push;
  logic                 do_pop;

  assign full    = (count == CNT_W'(BUF_DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  assign head_valid = ~empty & ent_valid[rd_ptr];
  assign head_addr  = ent_addr[rd_ptr];
  assign head_data  = ent_data[rd_ptr];

  // Kill is applied before the push so an entry enqueued in the same cycle
  // as a matching pipe write stays valid (it is younger than that write).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ent_valid <= '0;
    end else begin
      for (int unsigned i = 0; i < BUF_DEPTH; i++) begin
        if (kill && (ent_addr[i] == kill_addr)) ent_valid[i] <= 1'b0;
      end
      if (do_push) ent_valid[wr_ptr] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      ent_addr[wr_ptr] <= push_addr;
      ent_data[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      if (do_push && !do_pop)      count <= count + CNT_W'(1);
      else if (do_pop && !do_push) count <= count - CNT_W'(1);
    end
  end

endmodule

// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter between MEM/WB writeback and a multi-cycle unit.
//   clk, resetIn (async, active-low)
//   pipeWeIn/pipeAddrIn/pipeDataIn : in-order writeback, always has priority
//   mcValidIn/mcAddrIn/mcDataIn, mcReadyOut : multi-cycle result handshake into the queue
//   stallReqOut : one-cycle MEM/WB freeze while a starved queue head is forced out
//   rfWeOut/rfAddrOut/rfDataOut : registered register-file write port
module wb_port_arbiter
  import wb_port_arbiter_pkg::*;
#(
  parameter int unsigned DATA_W       = DATA_W_DEF,
  parameter int unsigned ADDR_W       = ADDR_W_DEF,
  parameter int unsigned BUF_DEPTH    = 2,
  parameter int unsigned STARVE_LIMIT = 8
) (
  input  logic              clk,
  input  logic              resetIn,
  input  logic              pipeWeIn,
  input  logic [ADDR_W-1:0] pipeAddrIn,
  input  logic [DATA_W-1:0] pipeDataIn,
  input  logic              mcValidIn,
  input  logic [ADDR_W-1:0] mcAddrIn,
  input  logic [DATA_W-1:0] mcDataIn,
  output logic              mcReadyOut,
  output logic              stallReqOut,
  output logic              rfWeOut,
  output logic [ADDR_W-1:0] rfAddrOut,
  output logic [DATA_W-1:0] rfDataOut
);

  localparam int unsigned AGE_W = $clog2(STARVE_LIMIT) + 1;

  wb_state_e         state, state_next;
  logic [AGE_W-1:0]  age, age_next;
  logic              pipe_req;
  logic              mc_push;
  logic              pop;
  logic              head_live;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_data;
  logic              head_valid;
  logic [ADDR_W-1:0] head_addr;
  logic [DATA_W-1:0] head_data;
  logic              fifo_full;
  logic              fifo_empty;

  assign stallReqOut = (state == ST_FORCE);
  assign mcReadyOut  = resetIn & ~fifo_full;
  assign pipe_req    = pipeWeIn & (pipeAddrIn != ADDR_W'(X0_ADDR)) & ~stallReqOut;
  assign mc_push     = mcValidIn & mcReadyOut & (mcAddrIn != ADDR_W'(X0_ADDR));
  // A head superseded by this cycle's pipe write must neither age nor force a stall.
  assign head_live   = head_valid & ~(pipe_req & (pipeAddrIn == head_addr));

  wb_result_fifo #(
    .DATA_W   (DATA_W),
    .ADDR_W   (ADDR_W),
    .BUF_DEPTH(BUF_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (resetIn),
    .push      (mc_push),
    .push_addr (mcAddrIn),
    .push_data (mcDataIn),
    .pop       (pop),
    .kill      (pipe_req),
    .kill_addr (pipeAddrIn),
    .head_valid(head_valid),
    .head_addr (head_addr),
    .head_data (head_data),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  always_comb begin
    state_next = ST_NORMAL;
    age_next   = '0;
    pop        = 1'b0;
    sel_we     = 1'b0;
    sel_addr   = head_addr;
    sel_data   = head_data;
    case (state)
      ST_FORCE: begin
        pop    = ~fifo_empty;
        sel_we = head_valid;
      end
      default: begin
        if (pipe_req) begin
          sel_we   = 1'b1;
          sel_addr = pipeAddrIn;
          sel_data = pipeDataIn;
          if (head_live) begin
            if (age == AGE_W'(STARVE_LIMIT - 1)) state_next = ST_FORCE;
            else                                 age_next   = age + AGE_W'(1);
          end
        end else begin
          pop    = ~fifo_empty;
          sel_we = head_valid;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge resetIn) begin
    if (!resetIn) begin
      state <= ST_NORMAL;
      age   <= '0;
    end else begin
      state <= state_next;
      age   <= age_next;
    end
  end

  always_ff @(posedge clk or negedge resetIn) begin
    if (!resetIn) begin
      rfWeOut   <= 1'b0;
      rfAddrOut <= '0;
      rfDataOut <= '0;
    end else begin
      rfWeOut <= sel_we;
      if (sel_we) begin
        rfAddrOut <= sel_addr;
        rfDataOut <= sel_data;
      end
    end
  end

endmodule

// File: tb/tb_wb_port_arbiter.sv
module tb_wb_port_arbiter;

  localparam int unsigned DW    = 32;
  localparam int unsigned AW    = 5;
  localparam int unsigned DEPTH = 2;
  localparam int unsigned LIMIT = 8;

  logic          clk = 1'b0;
  logic          resetIn;
  logic          pipeWeIn;
  logic [AW-1:0] pipeAddrIn;
  logic [DW-1:0] pipeDataIn;
  logic          mcValidIn;
  logic [AW-1:0] mcAddrIn;
  logic [DW-1:0] mcDataIn;
  logic          mcReadyOut;
  logic          stallReqOut;
  logic          rfWeOut;
  logic [AW-1:0] rfAddrOut;
  logic [DW-1:0] rfDataOut;

  always #5 clk = ~clk;

  wb_port_arbiter #(
    .DATA_W      (DW),
    .ADDR_W      (AW),
    .BUF_DEPTH   (DEPTH),
    .STARVE_LIMIT(LIMIT)
  ) dut (
    .clk        (clk),
    .resetIn    (resetIn),
    .pipeWeIn   (pipeWeIn),
    .pipeAddrIn (pipeAddrIn),
    .pipeDataIn (pipeDataIn),
    .mcValidIn  (mcValidIn),
    .mcAddrIn   (mcAddrIn),
    .mcDataIn   (mcDataIn),
    .mcReadyOut (mcReadyOut),
    .stallReqOut(stallReqOut),
    .rfWeOut    (rfWeOut),
    .rfAddrOut  (rfAddrOut),
    .rfDataOut  (rfDataOut)
  );

  // Reference model: the queue as a list of pending results in program order.
  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    bit            valid;
  } ent_t;

  ent_t mq[$];
  int   m_age;
  bit   m_force;
  int   n_cmp;
  int   n_bad;
  bit   last_xfer;
  int   stall_cnt;
  int   stall_at;
  int   cyc_idx;
  int   writes9;
  logic [DW-1:0] last9;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_age   = 0;
    m_force = 0;
  endtask

  // Drive one cycle (called just after a rising edge), check handshake/stall
  // mid-cycle, then check the registered write after the next edge.
  task automatic cycle(input logic we, input logic [AW-1:0] pa, input logic [DW-1:0] pd,
                       input logic mv, input logic [AW-1:0] ma, input logic [DW-1:0] md);
    bit            exp_we;
    bit            preq;
    bit            xfer;
    bit            popped;
    logic [AW-1:0] ea;
    logic [DW-1:0] ed;
    ent_t          e;
    pipeWeIn   = we;
    pipeAddrIn = pa;
    pipeDataIn = pd;
    mcValidIn  = mv;
    mcAddrIn   = ma;
    mcDataIn   = md;
    #1;
    chk("mc_ready", {31'd0, mcReadyOut}, {31'd0, (mq.size() < DEPTH)});
    chk("stall", {31'd0, stallReqOut}, {31'd0, m_force});
    if (stallReqOut) begin
      stall_cnt++;
      stall_at = cyc_idx;
    end
    exp_we = 0;
    popped = 0;
    ea     = '0;
    ed     = '0;
    preq   = we && (pa != 0) && !m_force;
    xfer   = mv && (mq.size() < DEPTH);
    if (m_force || (!preq && mq.size() > 0)) begin
      popped = 1;
      e = mq.pop_front();
      if (e.valid) begin
        exp_we = 1;
        ea     = e.addr;
        ed     = e.data;
      end
    end else if (preq) begin
      exp_we = 1;
      ea     = pa;
      ed     = pd;
      foreach (mq[i]) if (mq[i].addr == pa) mq[i].valid = 0;
    end
    if (m_force) begin
      m_force = 0;
      m_age   = 0;
    end else if (!popped && mq.size() > 0 && mq[0].valid) begin
      if (m_age == int'(LIMIT) - 1) m_force = 1;
      else                          m_age++;
    end else begin
      m_age = 0;
    end
    if (xfer && ma != 0) mq.push_back('{ma, md, 1'b1});
    last_xfer = xfer;
    @(posedge clk);
    #1;
    cyc_idx++;
    chk("rf_we", {31'd0, rfWeOut}, {31'd0, exp_we});
    if (exp_we) begin
      chk("rf_addr", {27'd0, rfAddrOut}, {27'd0, ea});
      chk("rf_data", rfDataOut, ed);
    end
    if (rfWeOut && rfAddrOut == 5'd9) begin
      writes9++;
      last9 = rfDataOut;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, '0, '0, 1'b0, '0, '0);
  endtask

  initial begin
    n_cmp = 0; n_bad = 0; stall_cnt = 0; stall_at = -1; cyc_idx = 0;
    writes9 = 0; last9 = '0;
    model_reset();

    // Reset held with an active pipe write
    resetIn = 1'b0;
    pipeWeIn = 1'b1; pipeAddrIn = 5'd5; pipeDataIn = 32'hA5;
    mcValidIn = 1'b1; mcAddrIn = 5'd3; mcDataIn = 32'h3;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_we", {31'd0, rfWeOut}, 32'd0);
    chk("rst_addr", {27'd0, rfAddrOut}, 32'd0);
    chk("rst_data", rfDataOut, 32'd0);
    chk("rst_ready", {31'd0, mcReadyOut}, 32'd0);
    chk("rst_stall", {31'd0, stallReqOut}, 32'd0);
    pipeWeIn = 1'b0; mcValidIn = 1'b0;
    resetIn = 1'b1;
    @(posedge clk);
    #1;
    chk("rel_ready", {31'd0, mcReadyOut}, 32'd1);

    // Pipe only, including a dropped x0 write
    cycle(1'b1, 5'd5, 32'hA5, 1'b0, '0, '0);
    cycle(1'b1, 5'd0, 32'h55, 1'b0, '0, '0);

    // Multi-cycle only: two-cycle latency
    cycle(1'b0, '0, '0, 1'b1, 5'd7, 32'h11);
    idle(2);

    // Three back-to-back results against a busy pipe fill the queue
    cycle(1'b1, 5'd1, 32'h101, 1'b1, 5'd12, 32'hC0);
    cycle(1'b1, 5'd2, 32'h102, 1'b1, 5'd13, 32'hC1);
    cycle(1'b1, 5'd3, 32'h103, 1'b1, 5'd14, 32'hC2);
    chk("full_no_accept", {31'd0, last_xfer}, 32'd0);
    last_xfer = 1'b0;
    for (int k = 0; k < 4 && !last_xfer; k++) cycle(1'b0, '0, '0, 1'b1, 5'd14, 32'hC2);
    chk("third_accepted", {31'd0, last_xfer}, 32'd1);
    idle(4);

    // Starvation: one queued result, pipe writes every cycle
    cyc_idx = 0; stall_cnt = 0; stall_at = -1;
    cycle(1'b1, 5'd2, 32'h200, 1'b1, 5'd7, 32'h11);
    cyc_idx = 0;
    for (int i = 0; i < 12; i++) cycle(1'b1, 5'd1 + 5'(i % 3), 32'h300 + i, 1'b0, '0, '0);
    chk("starve_stalls", stall_cnt, 32'd1);
    chk("starve_at", stall_at, 32'd8);
    idle(2);

    // Supersede: queued 9/1 is overtaken by pipe 9/2
    writes9 = 0;
    cycle(1'b1, 5'd3, 32'h33, 1'b1, 5'd9, 32'd1);
    cycle(1'b1, 5'd9, 32'd2, 1'b0, '0, '0);
    idle(4);
    chk("sup_writes", writes9, 32'd1);
    chk("sup_data", last9, 32'd2);

    // Async reset mid-cycle with two queued entries
    cycle(1'b1, 5'd3, 32'h44, 1'b1, 5'd10, 32'hAA);
    cycle(1'b1, 5'd4, 32'h45, 1'b1, 5'd11, 32'hBB);
    pipeWeIn = 1'b0; mcValidIn = 1'b0;
    #3 resetIn = 1'b0;
    #1;
    chk("mid_rst_we", {31'd0, rfWeOut}, 32'd0);
    chk("mid_rst_addr", {27'd0, rfAddrOut}, 32'd0);
    chk("mid_rst_data", rfDataOut, 32'd0);
    chk("mid_rst_ready", {31'd0, mcReadyOut}, 32'd0);
    model_reset();
    @(posedge clk);
    #1 resetIn = 1'b1;
    idle(4);

    // Randomized traffic against the model
    for (int i = 0; i < 2000; i++) begin
      cycle(($urandom_range(0, 9) < 7), 5'($urandom_range(0, 7)), $urandom,
            ($urandom_range(0, 1) == 1), 5'($urandom_range(0, 7)), $urandom);
    end
    idle(6);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
